// File: rtl/ysyx_23060191_mem_arb_if.sv
// Request/response bus shared by the fetch port, the load/store port and the memory port.
// The master drives the request fields, and the slave returns ready and the response.
interface ysyx_23060191_mem_arb_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wmask;
    logic              resp_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, addr, wen, wdata, wmask,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask,
        output req_ready, resp_valid, rdata
    );
endinterface

// File: rtl/ysyx_23060191_mem_arb.sv
// Arbitrates IFU and LSU onto one memory port, with at most one transaction outstanding.
// Define YSYX_23060191_ARB_RR_EN to break ties round-robin; by default the LSU wins ties.
module ysyx_23060191_mem_arb #(
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    ysyx_23060191_mem_arb_if.slave  ifu,
    ysyx_23060191_mem_arb_if.slave  lsu,
    ysyx_23060191_mem_arb_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_reg, state_next;
    logic              owner_lsu_reg;
    logic [DATA_W-1:0] addr_reg;
    logic              wen_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [3:0]        wmask_reg;

    logic grant_lsu;
    logic ifu_take;
    logic lsu_take;
    logic in_req;
    logic resp_hit;

`ifdef YSYX_23060191_ARB_RR_EN
    // Set to 1 when the LSU held the last grant. It resets to LSU so that the first tie goes to the IFU.
    logic last_lsu_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu_reg <= 1'b1;
        end else if (ifu_take || lsu_take) begin
            last_lsu_reg <= lsu_take;
        end
    end

    always_comb begin
        grant_lsu = lsu.req_valid;
        if (ifu.req_valid && lsu.req_valid) begin
            grant_lsu = ~last_lsu_reg;
        end
    end
`else
    always_comb begin
        grant_lsu = lsu.req_valid;
    end
`endif

    // Every output is gated by rst, so all ports read zero during reset.
    always_comb begin
        ifu_take = ~rst && (state_reg == IDLE) && ifu.req_valid && ~grant_lsu;
        lsu_take = ~rst && (state_reg == IDLE) && lsu.req_valid && grant_lsu;
        in_req   = ~rst && (state_reg == REQ);
        resp_hit = ~rst && (state_reg == WAIT) && mem.resp_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ifu_take || lsu_take) state_next = REQ;
            REQ:     if (mem.req_ready)        state_next = WAIT;
            WAIT:    if (mem.resp_valid)       state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A fetch is always a full read: no write enable and no byte lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_lsu_reg <= 1'b0;
            addr_reg      <= '0;
            wen_reg       <= 1'b0;
            wdata_reg     <= '0;
            wmask_reg     <= '0;
        end else if (lsu_take) begin
            owner_lsu_reg <= 1'b1;
            addr_reg      <= lsu.addr;
            wen_reg       <= lsu.wen;
            wdata_reg     <= lsu.wdata;
            wmask_reg     <= lsu.wmask;
        end else if (ifu_take) begin
            owner_lsu_reg <= 1'b0;
            addr_reg      <= ifu.addr;
            wen_reg       <= 1'b0;
            wdata_reg     <= '0;
            wmask_reg     <= '0;
        end
    end

    always_comb begin
        ifu.req_ready  = ifu_take;
        lsu.req_ready  = lsu_take;
        mem.req_valid  = in_req;
        mem.addr       = in_req ? addr_reg  : '0;
        mem.wen        = in_req ? wen_reg   : 1'b0;
        mem.wdata      = in_req ? wdata_reg : '0;
        mem.wmask      = in_req ? wmask_reg : '0;
        ifu.resp_valid = resp_hit && ~owner_lsu_reg;
        lsu.resp_valid = resp_hit && owner_lsu_reg;
        ifu.rdata      = (resp_hit && ~owner_lsu_reg) ? mem.rdata : '0;
        lsu.rdata      = (resp_hit && owner_lsu_reg)  ? mem.rdata : '0;
    end
endmodule

// File: tb/tb_ysyx_23060191_mem_arb.sv
// Directed bench for ysyx_23060191_mem_arb: expected responses go into a scoreboard queue when a
// request is accepted, and a monitor compares them against the responses the arbiter produces.
module tb_ysyx_23060191_mem_arb;
    logic clk;
    logic rst;

    ysyx_23060191_mem_arb_if #(.DATA_W(32)) ifu_bus ();
    ysyx_23060191_mem_arb_if #(.DATA_W(32)) lsu_bus ();
    ysyx_23060191_mem_arb_if #(.DATA_W(32)) mem_bus ();

    ysyx_23060191_mem_arb #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu_bus),
        .lsu (lsu_bus),
        .mem (mem_bus)
    );

    typedef struct packed {
        logic        is_lsu;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef YSYX_23060191_ARB_RR_EN
    localparam bit FIRST_TIE_LSU = 1'b0;
`else
    localparam bit FIRST_TIE_LSU = 1'b1;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: checks each response pulse against the oldest scoreboard entry.
    always @(negedge clk) begin
        #2;
        if (ifu_bus.resp_valid === 1'b1 || lsu_bus.resp_valid === 1'b1) begin
            chk("sb_single_resp", {31'b0, ifu_bus.resp_valid & lsu_bus.resp_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("sb_resp_when_empty", {31'b0, ifu_bus.resp_valid | lsu_bus.resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_owner", {31'b0, lsu_bus.resp_valid}, {31'b0, e.is_lsu});
                chk("sb_rdata", e.is_lsu ? lsu_bus.rdata : ifu_bus.rdata, e.rdata);
                chk("sb_other_rdata", e.is_lsu ? ifu_bus.rdata : lsu_bus.rdata, 32'd0);
                $display("resp owner=%s rdata=%h", lsu_bus.resp_valid ? "lsu" : "ifu",
                         lsu_bus.resp_valid ? lsu_bus.rdata : ifu_bus.rdata);
            end
        end
    end

    // Called in the accept cycle. Drops the winner's valid, serves the request after `delay`
    // stall cycles, returns rd, and ends in the following IDLE cycle.
    task automatic serve(input bit is_lsu, input logic [31:0] a, input bit w,
                         input logic [31:0] wd, input logic [3:0] wm,
                         input logic [31:0] rd, input int delay);
        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (is_lsu) lsu_bus.req_valid = 1'b0;
                else        ifu_bus.req_valid = 1'b0;
            end
            mem_bus.req_ready = (i == delay);
            #1;
            chk("req_mem_valid", {31'b0, mem_bus.req_valid}, 32'd1);
            chk("req_mem_addr", mem_bus.addr, a);
            chk("req_mem_wen", {31'b0, mem_bus.wen}, {31'b0, w});
            chk("req_mem_wdata", mem_bus.wdata, wd);
            chk("req_mem_wmask", {28'b0, mem_bus.wmask}, {28'b0, wm});
            chk("req_ready_low", {30'b0, ifu_bus.req_ready, lsu_bus.req_ready}, 32'd0);
        end
        @(negedge clk);
        mem_bus.req_ready  = 1'b0;
        mem_bus.resp_valid = 1'b1;
        mem_bus.rdata      = rd;
        #1;
        chk("wait_mem_valid", {31'b0, mem_bus.req_valid}, 32'd0);
        chk("wait_owner_resp", {31'b0, is_lsu ? lsu_bus.resp_valid : ifu_bus.resp_valid}, 32'd1);
        chk("wait_ready_low", {30'b0, ifu_bus.req_ready, lsu_bus.req_ready}, 32'd0);
        @(negedge clk);
        mem_bus.resp_valid = 1'b0;
        mem_bus.rdata      = 32'd0;
        #1;
        chk("after_resp_valid", {30'b0, ifu_bus.resp_valid, lsu_bus.resp_valid}, 32'd0);
        chk("after_resp_rdata", ifu_bus.rdata | lsu_bus.rdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ifu_bus.req_valid = 1'b0; ifu_bus.addr = '0; ifu_bus.wen = 1'b0;
        ifu_bus.wdata = '0; ifu_bus.wmask = '0;
        lsu_bus.req_valid = 1'b0; lsu_bus.addr = '0; lsu_bus.wen = 1'b0;
        lsu_bus.wdata = '0; lsu_bus.wmask = '0;
        mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b0; mem_bus.rdata = '0;

        // While reset is held, every output must stay 0 even with requests and a response present.
        @(negedge clk);
        ifu_bus.req_valid = 1'b1; lsu_bus.req_valid = 1'b1; mem_bus.resp_valid = 1'b1;
        #1;
        chk("rst_ready", {30'b0, ifu_bus.req_ready, lsu_bus.req_ready}, 32'd0);
        chk("rst_resp", {30'b0, ifu_bus.resp_valid, lsu_bus.resp_valid}, 32'd0);
        chk("rst_mem_valid", {31'b0, mem_bus.req_valid}, 32'd0);
        @(negedge clk);
        ifu_bus.req_valid = 1'b0; lsu_bus.req_valid = 1'b0; mem_bus.resp_valid = 1'b0;
        rst = 1'b0;
        $display("reset released");

        // Tie: LSU load and IFU fetch are both valid in IDLE.
        @(negedge clk);
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0004;
        lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8000_1000; lsu_bus.wen = 1'b0;
        #1;
        chk("tie_ifu_ready", {31'b0, ifu_bus.req_ready}, {31'b0, ~FIRST_TIE_LSU});
        chk("tie_lsu_ready", {31'b0, lsu_bus.req_ready}, {31'b0, FIRST_TIE_LSU});
        exp_q.push_back({FIRST_TIE_LSU, FIRST_TIE_LSU ? 32'h1111_1111 : 32'h2222_2222});
        $display("tie first grant lsu=%0d", FIRST_TIE_LSU);
        serve(FIRST_TIE_LSU, FIRST_TIE_LSU ? 32'h8000_1000 : 32'h8000_0004, 1'b0, 32'd0, 4'd0,
              FIRST_TIE_LSU ? 32'h1111_1111 : 32'h2222_2222, 0);
        // The losing requester kept its valid asserted and must be granted at T+3.
        chk("tie_second_ifu_ready", {31'b0, ifu_bus.req_ready}, {31'b0, FIRST_TIE_LSU});
        chk("tie_second_lsu_ready", {31'b0, lsu_bus.req_ready}, {31'b0, ~FIRST_TIE_LSU});
        exp_q.push_back({~FIRST_TIE_LSU, FIRST_TIE_LSU ? 32'h2222_2222 : 32'h1111_1111});
        serve(~FIRST_TIE_LSU, FIRST_TIE_LSU ? 32'h8000_0004 : 32'h8000_1000, 1'b0, 32'd0, 4'd0,
              FIRST_TIE_LSU ? 32'h2222_2222 : 32'h1111_1111, 0);

        // IFU-only fetch with a zero-wait memory.
        @(negedge clk);
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0000;
        #1;
        chk("fetch_ifu_ready", {31'b0, ifu_bus.req_ready}, 32'd1);
        chk("fetch_lsu_ready", {31'b0, lsu_bus.req_ready}, 32'd0);
        exp_q.push_back({1'b0, 32'h0000_0413});
        $display("fetch addr=80000000");
        serve(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'd0, 32'h0000_0413, 0);

        // LSU store with the memory stalling ready for 3 cycles.
        @(negedge clk);
        lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8000_2000; lsu_bus.wen = 1'b1;
        lsu_bus.wdata = 32'hDEAD_BEEF; lsu_bus.wmask = 4'hF;
        #1;
        chk("store_lsu_ready", {31'b0, lsu_bus.req_ready}, 32'd1);
        exp_q.push_back({1'b1, 32'h0000_0000});
        $display("store addr=80002000 wdata=deadbeef");
        serve(1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 3);
        lsu_bus.wen = 1'b0; lsu_bus.wdata = '0; lsu_bus.wmask = '0;

        // A stray response in IDLE and in REQ must be ignored.
        @(negedge clk);
        mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'h0000_0055;
        #1;
        chk("stray_idle_resp", {30'b0, ifu_bus.resp_valid, lsu_bus.resp_valid}, 32'd0);
        @(negedge clk);
        mem_bus.resp_valid = 1'b0; mem_bus.rdata = '0;
        lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8000_3000;
        #1;
        chk("stray_lsu_ready", {31'b0, lsu_bus.req_ready}, 32'd1);
        exp_q.push_back({1'b1, 32'hCAFE_F00D});
        @(negedge clk);
        lsu_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b0;
        mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'h0000_1234;
        #1;
        chk("stray_req_mem_valid", {31'b0, mem_bus.req_valid}, 32'd1);
        chk("stray_req_resp", {30'b0, ifu_bus.resp_valid, lsu_bus.resp_valid}, 32'd0);
        @(negedge clk);
        mem_bus.resp_valid = 1'b0; mem_bus.rdata = '0; mem_bus.req_ready = 1'b1;
        @(negedge clk);
        mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'hCAFE_F00D;
        #1;
        chk("stray_real_resp", {31'b0, lsu_bus.resp_valid}, 32'd1);
        @(negedge clk);
        mem_bus.resp_valid = 1'b0; mem_bus.rdata = '0;

        // Reset in WAIT drops the fetch, and a late response afterwards is ignored.
        @(negedge clk);
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0008;
        #1;
        chk("rstwait_ifu_ready", {31'b0, ifu_bus.req_ready}, 32'd1);
        @(negedge clk);
        ifu_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
        @(negedge clk);
        mem_bus.req_ready = 1'b0; rst = 1'b1;
        #1;
        chk("rstwait_mem_valid", {31'b0, mem_bus.req_valid}, 32'd0);
        chk("rstwait_resp", {30'b0, ifu_bus.resp_valid, lsu_bus.resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'h0000_0BAD;
        #1;
        chk("rstwait_stray_resp", {30'b0, ifu_bus.resp_valid, lsu_bus.resp_valid}, 32'd0);
        chk("rstwait_stray_rdata", ifu_bus.rdata | lsu_bus.rdata, 32'd0);
        chk("rstwait_mem_idle", {31'b0, mem_bus.req_valid}, 32'd0);
        @(negedge clk);
        mem_bus.resp_valid = 1'b0; mem_bus.rdata = '0;
        ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_000C;
        #1;
        chk("rstwait_idle_grant", {31'b0, ifu_bus.req_ready}, 32'd1);
        @(negedge clk);
        ifu_bus.req_valid = 1'b0;
        $display("reset in wait done");

        repeat (2) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_23060191_mem_arb.md
YSYX_23060191_MEM_ARB -- requirements
Module: ysyx_23060191_mem_arb

Interface
REQ-001 Parameter DATA_W SHALL be: DATA_W, default 32, width of address and data buses (matches `CPU_WIDTH).
REQ-002 Clock and reset SHALL be: one clock and synchronous, active-high reset, as follows.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-003 IFU master ports SHALL be:
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  fetch request accepted.
- ifu_addr  in  DATA_W  fetch address (pc).
- ifu_resp_valid  out  1  fetch data valid, one-cycle pulse.
- ifu_rdata  out  DATA_W  fetched instruction.
REQ-004 LSU master ports SHALL be:
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  request accepted.
- lsu_addr  in  DATA_W  access address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  4  byte write mask.
- lsu_resp_valid  out  1  load data / store ack, one-cycle pulse.
- lsu_rdata  out  DATA_W  load data.
REQ-005 Memory port SHALL be:
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts.
- mem_addr  out  DATA_W  address.
- mem_wen  out  1  write enable.
- mem_wdata  out  DATA_W  write data.
- mem_wmask  out  4  write mask.
- mem_resp_valid  in  1  response valid.
- mem_rdata  in  DATA_W  read data.

Function
REQ-006 FSM SHALL have exactly three states: IDLE, REQ, WAIT; one outstanding transaction max.
REQ-007 In IDLE, the arbiter SHALL assert ready combinationally to the winning valid master only; on valid&&ready, latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and owner, then go to REQ.
REQ-008 In REQ, mem_req_valid SHALL be 1 with latched fields held stable; on mem_req_ready=1, go to WAIT.
REQ-009 mem_resp_valid SHALL be ignored outside WAIT; memory never responds in the accept cycle.
REQ-010 In WAIT, on mem_resp_valid=1, the owner's resp_valid SHALL pulse for that cycle only, with rdata = mem_rdata; next state IDLE.
REQ-011 Non-owner resp_valid SHALL be 0 and its rdata SHALL be 0; both rdata outputs are 0 when no response is present.
REQ-012 Both req_ready outputs SHALL be 0 in REQ and WAIT; mem_req_valid SHALL be 0 in IDLE and WAIT.
REQ-013 Minimum latency with zero-wait memory SHALL be: accept at T, mem handshake at T+1, response at T+2, next grant at T+3.
REQ-014 Stores SHALL complete with an lsu_resp_valid pulse (ack) like loads.
REQ-015 Default arbitration: simultaneous valid requests in IDLE SHALL grant the LSU; a lone requester SHALL always be granted.

Reset
REQ-016 On rst=1, state SHALL return to IDLE and all outputs SHALL be 0, including when a transaction is in flight.
REQ-017 An in-flight transaction interrupted by reset SHALL be dropped without a response; a mem_resp_valid arriving after reset SHALL be ignored.

Configuration
REQ-018 With YSYX_23060191_ARB_RR_EN defined, ties SHALL be resolved round-robin via a last-grant register updated on every grant. The register resets to LSU, so the first tie after reset goes to IFU.
REQ-019 Without YSYX_23060191_ARB_RR_EN, the last-grant register SHALL be absent and fixed LSU priority (REQ-015) SHALL apply.

Verification
REQ-020 IFU-only fetch, addr=0x80000000, memory ready=1, rdata=0x00000413 -> ifu_resp_valid pulse at T+2 with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
REQ-021 IFU and LSU valid together, LSU load addr=0x80001000 -> LSU granted first, IFU granted at T+3; with RR_EN, IFU first, then LSU at T+3.
REQ-022 LSU store addr=0x80002000, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready low 3 cycles -> mem fields stable while waiting, lsu_resp_valid pulses exactly once after mem_resp_valid.
REQ-023 rst asserted in WAIT, then a stray mem_resp_valid=1 -> no resp_valid pulse, all outputs 0, state IDLE.
REQ-024 mem_resp_valid=1 forced in IDLE and REQ -> no resp_valid on either master.
